// File: rtl/t5_hsch.sv
// Four-hart barrel scheduler: round-robin fetch arbitration, writeback
// tagging through a PDEP-deep pipe, and a power-on register-file zero sweep.
module t5_hsch #(
  parameter int XLEN = 32,
  parameter int PDEP = 3
) (
  input  logic            sclk,
  input  logic            srstn,
  input  logic [3:0]      hena,
  input  logic [3:0]      hwait,
  input  logic            wb_wre,
  input  logic [4:0]      wb_a,
  input  logic [XLEN-1:0] wb_d,
  output logic [1:0]      fhart,
  output logic            fvld,
  output logic [1:0]      mhart,
  output logic [4:0]      rd0a,
  output logic [XLEN-1:0] rd0d,
  output logic            mwre,
  output logic            busy
);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state, state_nx;
  logic [6:0] cnt;
  logic       done;
  logic [1:0] ptr;
  logic [2:0] sr [PDEP];
  logic [3:0] elig;
  logic       gnt_v;
  logic [1:0] gnt_h;
  logic       tag_v;
  logic [1:0] tag_h;

  assign elig = hena & ~hwait;
  assign {tag_v, tag_h} = sr[PDEP-1];

  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == INIT && done) state_nx = RUN;
  end

  // Search ptr+1 .. ptr+4 (wraps to ptr itself last).
  always_comb begin
    gnt_v = 1'b0;
    gnt_h = ptr;
    for (int k = 1; k <= 4; k++) begin
      if (!gnt_v && elig[ptr + 2'(k)]) begin
        gnt_v = 1'b1;
        gnt_h = ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      cnt   <= '0;
      done  <= 1'b0;
      ptr   <= 2'd3;
      fhart <= '0;
      fvld  <= 1'b0;
      mhart <= '0;
      rd0a  <= '0;
      rd0d  <= '0;
      mwre  <= 1'b0;
      busy  <= 1'b1;
      for (int k = 0; k < PDEP; k++) sr[k] <= '0;
    end else begin
      sr[0] <= {fvld, fhart};
      for (int k = 1; k < PDEP; k++) sr[k] <= sr[k-1];
      unique case (state)
        INIT: begin
          fvld <= 1'b0;
          if (done) begin
            busy <= 1'b0;
            mwre <= 1'b0;
          end else begin
            mwre  <= 1'b1;
            mhart <= cnt[6:5];
            rd0a  <= cnt[4:0];
            rd0d  <= '0;
            cnt   <= cnt + 7'd1;
            done  <= (cnt == 7'd127);
          end
        end
        RUN: begin
          fvld <= gnt_v;
          if (gnt_v) begin
            fhart <= gnt_h;
            ptr   <= gnt_h;
          end
          // x0 is hard-wired zero, so its writes never reach the file.
          mwre  <= wb_wre & tag_v & (wb_a != 5'd0);
          mhart <= tag_h;
          rd0a  <= wb_a;
          rd0d  <= wb_d;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t5_hsch.sv
// Directed bench for t5_hsch: sweep, arbitration table, writeback tagging,
// and mid-sweep reset.
module tb_t5_hsch;

  logic        sclk = 1'b0;
  logic        srstn;
  logic [3:0]  hena, hwait;
  logic        wb_wre;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;
  logic [1:0]  fhart, mhart;
  logic        fvld, mwre, busy;
  logic [4:0]  rd0a;
  logic [31:0] rd0d;

  int passed = 0;
  int total  = 0;

  always #5 sclk = ~sclk;

  t5_hsch #(.XLEN(32), .PDEP(3)) dut (
    .sclk(sclk), .srstn(srstn), .hena(hena), .hwait(hwait),
    .wb_wre(wb_wre), .wb_a(wb_a), .wb_d(wb_d),
    .fhart(fhart), .fvld(fvld), .mhart(mhart), .rd0a(rd0a),
    .rd0d(rd0d), .mwre(mwre), .busy(busy)
  );

  typedef struct {
    logic [3:0] hena;
    logic [3:0] hwait;
    logic       fvld;
    logic [1:0] fhart;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] he, input logic [3:0] hw,
                       input logic we, input logic [4:0] a,
                       input logic [31:0] d);
    hena = he; hwait = hw; wb_wre = we; wb_a = a; wb_d = d;
    tick();
  endtask

  task automatic sweep_check();
    for (int i = 0; i < 128; i++) begin
      tick();
      chk($sformatf("sweep%0d", i),
          {22'd0, busy, fvld, mwre, mhart, rd0a, rd0d},
          {22'd0, 1'b1, 1'b0, 1'b1, 7'(i), 32'h0});
    end
    tick();
    chk("busy_fall", {61'd0, busy, fvld, mwre}, 64'd0);
  endtask

  task automatic wb_case(input logic [1:0] h, input logic [4:0] a,
                         input logic [31:0] d, input logic stall,
                         input logic exp_we);
    logic [3:0] oh;
    oh = 4'b0001 << h;
    drive(oh, 4'b0000, 1'b0, 5'd0, 32'h0);
    chk("wb_issue", {61'd0, fvld, fhart}, {61'd0, 1'b1, h});
    for (int i = 0; i < 3; i++) begin
      if (stall) drive(oh, oh, 1'b0, 5'd0, 32'h0);
      else       drive(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);
      chk("wb_idle", {63'd0, fvld}, 64'd0);
    end
    drive(4'b0000, 4'b0000, 1'b1, a, d);
    chk($sformatf("wb_h%0d_a%0d", h, a),
        {24'd0, mwre, mhart, rd0a, rd0d},
        {24'd0, exp_we, h, a, d});
  endtask

  vec_t tbl [18];

  initial begin
    tbl = '{
      '{4'b1111, 4'b0000, 1'b1, 2'd0},
      '{4'b1111, 4'b0000, 1'b1, 2'd1},
      '{4'b1111, 4'b0000, 1'b1, 2'd2},
      '{4'b1111, 4'b0000, 1'b1, 2'd3},
      '{4'b1111, 4'b0100, 1'b1, 2'd0},
      '{4'b1111, 4'b0100, 1'b1, 2'd1},
      '{4'b1111, 4'b0100, 1'b1, 2'd3},
      '{4'b1111, 4'b0100, 1'b1, 2'd0},
      '{4'b1111, 4'b0100, 1'b1, 2'd1},
      '{4'b1111, 4'b0100, 1'b1, 2'd3},
      '{4'b1111, 4'b0000, 1'b1, 2'd0},
      '{4'b1111, 4'b0000, 1'b1, 2'd1},
      '{4'b1111, 4'b0000, 1'b1, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 2'd2},
      '{4'b0010, 4'b0000, 1'b1, 2'd1},
      '{4'b0010, 4'b0000, 1'b1, 2'd1},
      '{4'b0010, 4'b0000, 1'b1, 2'd1}
    };

    srstn = 1'b0;
    hena = 4'b1111; hwait = 4'b0000;
    wb_wre = 1'b1; wb_a = 5'd3; wb_d = 32'hFFFF_FFFF;
    #12;
    chk("reset_state",
        {21'd0, busy, fvld, fhart, mwre, mhart, rd0a, rd0d},
        {21'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 32'd0});
    @(negedge sclk);
    srstn = 1'b1;
    sweep_check();

    foreach (tbl[i]) begin
      drive(tbl[i].hena, tbl[i].hwait, 1'b0, 5'd0, 32'h0);
      chk($sformatf("arb%0d", i), {61'd0, fvld, fhart},
          {61'd0, tbl[i].fvld, tbl[i].fhart});
    end

    for (int i = 0; i < 4; i++) drive(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);
    drive(4'b0000, 4'b0000, 1'b1, 5'd3, 32'h1111_2222);
    chk("bubble_wr", {63'd0, mwre}, 64'd0);

    wb_case(2'd2, 5'd5,  32'hDEAD_BEEF, 1'b0, 1'b1);
    wb_case(2'd2, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0);
    wb_case(2'd3, 5'd9,  32'h1234_5678, 1'b1, 1'b1);
    wb_case(2'd1, 5'd31, 32'hA5A5_A5A5, 1'b0, 1'b1);

    hena = 4'b1111; hwait = 4'b0000; wb_wre = 1'b1; wb_a = 5'd3;
    @(negedge sclk);
    srstn = 1'b0;
    @(negedge sclk);
    srstn = 1'b1;
    for (int i = 0; i < 61; i++) tick();
    chk("entry60", {56'd0, mwre, mhart, rd0a}, {56'd0, 1'b1, 7'd60});
    #1 srstn = 1'b0;
    #1;
    chk("async_rst", {55'd0, busy, mwre, mhart, rd0a},
        {55'd0, 1'b1, 1'b0, 2'd0, 5'd0});
    @(negedge sclk);
    srstn = 1'b1;
    sweep_check();
    drive(4'b1111, 4'b0000, 1'b0, 5'd0, 32'h0);
    chk("post_rst_arb", {61'd0, fvld, fhart}, {61'd0, 1'b1, 2'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/t5_hsch.md
T5_HSCH -- requirements
Module: t5_hsch

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter PDEP, default 3, cycles from hart issue (fvld high) to writeback sample; legal 1..8.
REQ-003 SHALL have port sclk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port srstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port hena  input  4  per-hart enable, bit i = hart i.
REQ-006 SHALL have port hwait  input  4  per-hart stall request (e.g. pending load), bit i = hart i.
REQ-007 SHALL have port wb_wre  input  1  pipeline writeback request for the stage-PDEP instruction.
REQ-008 SHALL have port wb_a  input  5  writeback destination register index.
REQ-009 SHALL have port wb_d  input  XLEN  writeback data.
REQ-010 SHALL have port fhart  output  2  hart selected for fetch/register read.
REQ-011 SHALL have port fvld  output  1  fhart carries a valid issue slot this cycle.
REQ-012 SHALL have port mhart  output  2  register-file write hart (upper write address bits).
REQ-013 SHALL have port rd0a  output  5  register-file write index.
REQ-014 SHALL have port rd0d  output  XLEN  register-file write data.
REQ-015 SHALL have port mwre  output  1  register-file write enable.
REQ-016 SHALL have port busy  output  1  register-file initialisation in progress.

Function
REQ-017 SHALL implement states INIT and RUN; INIT entered on reset, RUN entered once the sweep completes; no return to INIT except via reset.
REQ-018 In INIT, SHALL hold a 7-bit sweep counter cnt; each cycle drive mwre=1, mhart=cnt[6:5], rd0a=cnt[4:0], rd0d=0 (registered outputs), then increment cnt.
REQ-019 Sweep SHALL write entries 0..127 exactly once, one per cycle, 128 consecutive cycles starting at the first edge after reset release.
REQ-020 busy SHALL be 1 from reset through the cycle presenting entry 127, and 0 from the next edge onward; state changes to RUN on that same edge.
REQ-021 In INIT, fvld SHALL be 0, and wb_wre, hena and hwait SHALL be ignored.
REQ-022 In RUN, eligible[i] = hena[i] & ~hwait[i], sampled at each edge.
REQ-023 Arbitration SHALL be round-robin from pointer ptr (last granted hart): search order ptr+1, ptr+2, ptr+3, ptr (mod 4); the first eligible hart is granted.
REQ-024 On a grant, the next edge SHALL set fhart=granted hart, fvld=1, ptr=granted hart.
REQ-025 With no eligible hart, the next edge SHALL set fvld=0; fhart and ptr hold.
REQ-026 The same hart MAY be granted on consecutive cycles only if it is the sole eligible hart.
REQ-027 SHALL carry {fvld, fhart} through a PDEP-stage shift register; stage PDEP (tag t) aligns with wb_wre/wb_a/wb_d.
REQ-028 In RUN, the edge after sampling SHALL set mwre = wb_wre & tag-valid & (wb_a != 0), mhart = tag hart, rd0a = wb_a, rd0d = wb_d.
REQ-029 Writes to index 0 SHALL be suppressed (mwre=0) so x0 stays zero for every hart.
REQ-030 Deasserting hena or asserting hwait for a hart SHALL NOT cancel its in-flight slots; those still write back.
REQ-031 wb_wre with an invalid tag (bubble) SHALL NOT write (mwre=0).
REQ-032 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-033 While srstn=0: state=INIT, cnt=0, ptr=3, fhart=0, fvld=0, mhart=0, rd0a=0, rd0d=0, mwre=0, busy=1, all shift-register stages invalid.
REQ-034 Reset asserted mid-sweep or mid-RUN SHALL take effect immediately and restart the full 128-entry sweep after release.

Verification
REQ-035 Reset release -> mwre=1 for exactly 128 cycles, {mhart,rd0a} = 0,1,...,127 in order, rd0d=0; busy falls the edge after entry 127; fvld=0 throughout.
REQ-036 RUN, hena=4'b1111, hwait=0 -> fhart sequence 0,1,2,3,0,... with fvld=1 every cycle.
REQ-037 RUN, hena=4'b1111, hwait=4'b0100 -> fhart 0,1,3,0,1,3; hwait=0 next -> hart 2 granted in its round-robin turn.
REQ-038 RUN, hena=4'b0000 -> fvld=0, fhart holds; then hena=4'b0010 -> fhart=1, fvld=1 the next cycle, every cycle thereafter.
REQ-039 PDEP=3, hart 2 issued at cycle N, wb_wre=1, wb_a=5, wb_d=32'hDEADBEEF at cycle N+3 -> at N+4 mwre=1, mhart=2, rd0a=5, rd0d=32'hDEADBEEF; same with wb_a=0 -> mwre=0.
REQ-040 Reset pulse at sweep entry 60 -> outputs reset asynchronously; after release the sweep restarts at entry 0 and runs all 128 entries.
